// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST 28147-89) decryption path.
// Holds the block/key widths and frame lengths used by the byte loader
// and the decryption stage, plus the loader state encoding.
package magma_pkg;

  localparam int BLOCK_W         = 64;
  localparam int KEY_W           = 256;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int BYTES_PER_KEY   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_CT,
    ST_HOLD
  } loader_state_e;

endpackage

// File: rtl/magma_dec_loader_if.sv
// Byte-stream handshake into the Magma decryption loader.
//   in_data   : byte payload
//   in_valid  : in_data / in_is_key valid
//   in_is_key : frame type, sampled on the first byte of a frame
//   in_ready  : loader accepts a byte this cycle
// master = byte source, slave = loader.
interface magma_dec_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_is_key;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_is_key,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_is_key,
    output in_ready
  );
endinterface

// File: rtl/magma_shift_in.sv
// Parameterised big-endian byte shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over ld)
//   ld         : shift din in at the low end
//   din        : incoming byte
//   shifted    : {stored bytes, din}; the full word that results once
//                the last byte of a frame is presented on din
// Only W-8 bits are stored: the final byte of a frame is taken straight
// from din by the consumer, so it never needs to be registered here.
module magma_shift_in #(
  parameter int W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] din,
  output logic [W:1] shifted
);

  logic [W-8:1] q;

  assign shifted = {q, din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= shifted[W-8:1];
    end
  end

endmodule

// File: rtl/magma_dec_loader.sv
// Byte-stream front end for the Magma decryption stage.
// Assembles a 256-bit key and 64-bit ciphertext blocks from a byte stream,
// updates them atomically on frame completion and holds each ciphertext
// stable for CORE_LATENCY cycles while the core evaluates it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : byte-stream handshake (slave side)
//   key         : key to the core, changes only on key-frame completion
//   ciphertext  : block to the core, changes only on block completion
//   key_loaded  : a complete key has been received since reset
//   key_update  : pulse, cycle after a key frame completes
//   dec_start   : pulse, first cycle ciphertext holds a new block
//   msg_strobe  : pulse, core message valid this cycle
//   err         : pulse, ciphertext byte arrived with no key loaded
module magma_dec_loader
  import magma_pkg::*;
#(
  parameter int CORE_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  magma_dec_loader_if.slave  bus,
  output logic [KEY_W:1]     key,
  output logic [BLOCK_W:1]   ciphertext,
  output logic               key_loaded,
  output logic               key_update,
  output logic               dec_start,
  output logic               msg_strobe,
  output logic               err
);

  localparam logic [3:0] HOLD_INIT = 4'(CORE_LATENCY);

  loader_state_e    state_q, state_d;
  logic [4:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic             accept;
  logic             key_ld, key_clr, key_we;
  logic             ct_ld, ct_clr, ct_we;
  logic             err_d, key_update_d, dec_start_d, msg_strobe_d;
  logic [KEY_W:1]   key_shifted;
  logic [BLOCK_W:1] ct_shifted;

  assign bus.in_ready = (state_q != ST_HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  magma_shift_in #(.W(KEY_W)) u_key_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (key_clr),
    .ld      (key_ld),
    .din     (bus.in_data),
    .shifted (key_shifted)
  );

  magma_shift_in #(.W(BLOCK_W)) u_ct_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ct_clr),
    .ld      (ct_ld),
    .din     (bus.in_data),
    .shifted (ct_shifted)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    key_ld       = 1'b0;
    key_clr      = 1'b0;
    key_we       = 1'b0;
    ct_ld        = 1'b0;
    ct_clr       = 1'b0;
    ct_we        = 1'b0;
    err_d        = 1'b0;
    key_update_d = 1'b0;
    dec_start_d  = 1'b0;
    msg_strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_is_key) begin
            key_ld     = 1'b1;
            byte_cnt_d = 5'd1;
            state_d    = ST_LOAD_KEY;
          end else if (key_loaded) begin
            ct_ld      = 1'b1;
            byte_cnt_d = 5'd1;
            state_d    = ST_LOAD_CT;
          end else begin
            // Ciphertext with no key: the byte is swallowed and flagged.
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD_KEY: begin
        if (accept) begin
          if (byte_cnt_q == 5'(BYTES_PER_KEY - 1)) begin
            key_we       = 1'b1;
            key_clr      = 1'b1;
            byte_cnt_d   = 5'd0;
            key_update_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            key_ld     = 1'b1;
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      ST_LOAD_CT: begin
        if (accept) begin
          if (byte_cnt_q == 5'(BYTES_PER_BLOCK - 1)) begin
            ct_we        = 1'b1;
            ct_clr       = 1'b1;
            byte_cnt_d   = 5'd0;
            hold_cnt_d   = HOLD_INIT;
            dec_start_d  = 1'b1;
            // With a one-cycle hold the first HOLD cycle is also the last.
            msg_strobe_d = (HOLD_INIT == 4'd1);
            state_d      = ST_HOLD;
          end else begin
            ct_ld      = 1'b1;
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q - 4'd1;
        // Registered pulse: raise it for the cycle where the count reads 1.
        msg_strobe_d = (hold_cnt_q == 4'd2);
        if (hold_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      key        <= '0;
      ciphertext <= '0;
      key_loaded <= 1'b0;
      key_update <= 1'b0;
      dec_start  <= 1'b0;
      msg_strobe <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      key_update <= key_update_d;
      dec_start  <= dec_start_d;
      msg_strobe <= msg_strobe_d;
      err        <= err_d;
      if (key_we) begin
        key        <= key_shifted;
        key_loaded <= 1'b1;
      end
      if (ct_we) begin
        ciphertext <= ct_shifted;
      end
    end
  end

endmodule

// File: tb/tb_magma_dec_loader.sv
module tb_magma_dec_loader;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  magma_dec_loader_if bus();

  logic [256:1] key;
  logic [64:1]  ciphertext;
  logic         key_loaded, key_update, dec_start, msg_strobe, err;

  magma_dec_loader #(.CORE_LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .key        (key),
    .ciphertext (ciphertext),
    .key_loaded (key_loaded),
    .key_update (key_update),
    .dec_start  (dec_start),
    .msg_strobe (msg_strobe),
    .err        (err)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level reference: a queue collects the bytes of the open frame;
  // a full frame is folded big-endian into the key or block. A block then
  // blocks the stream for L cycles (hold_left counts them down).
  logic [255:0] m_key;
  logic [63:0]  m_ct;
  bit           m_loaded;
  logic [7:0]   frame[$];
  bit           frame_key, in_frame;
  int           hold_left;
  bit           m_upd, m_dec, m_err;

  // Per-window traces of each pulse, observed vs expected, one bit per cycle.
  int            tcyc;
  logic [127:0]  o_dec, e_dec, o_msg, e_msg, o_upd, e_upd, o_err, e_err, o_nrdy, e_nrdy;

  logic [255:0] KEY_TV = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  logic [255:0] CT_TV  = 256'h4ee901e5c2d8ca3d;

  task automatic model_reset();
    m_key = '0; m_ct = '0; m_loaded = 0;
    frame.delete(); in_frame = 0; frame_key = 0;
    hold_left = 0; m_upd = 0; m_dec = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit k, output bit acc);
    logic [255:0] word;
    m_upd = 0; m_dec = 0; m_err = 0; acc = 0;
    if (hold_left > 0) begin
      hold_left--;
    end else if (v) begin
      acc = 1;
      if (!in_frame) begin
        if (k || m_loaded) begin
          in_frame = 1; frame_key = k; frame.push_back(d);
        end else begin
          m_err = 1;
        end
      end else begin
        frame.push_back(d);
      end
      if (in_frame && frame.size() == (frame_key ? 32 : 8)) begin
        word = '0;
        foreach (frame[i]) word = {word[247:0], frame[i]};
        if (frame_key) begin
          m_key = word; m_loaded = 1; m_upd = 1;
        end else begin
          m_ct = word[63:0]; hold_left = L; m_dec = 1;
        end
        frame.delete(); in_frame = 0;
      end
    end
  endtask

  task automatic win_start();
    tcyc = 0;
    o_dec = '0; e_dec = '0; o_msg = '0; e_msg = '0; o_upd = '0;
    e_upd = '0; o_err = '0; e_err = '0; o_nrdy = '0; e_nrdy = '0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit k, output bit acc);
    bus.in_valid = v; bus.in_data = d; bus.in_is_key = k;
    @(posedge clk);
    model_edge(v, d, k, acc);
    #1;
    tcyc++;
    if (tcyc < 128) begin
      o_dec[tcyc] = dec_start;     e_dec[tcyc] = m_dec;
      o_msg[tcyc] = msg_strobe;    e_msg[tcyc] = (hold_left == 1);
      o_upd[tcyc] = key_update;    e_upd[tcyc] = m_upd;
      o_err[tcyc] = err;           e_err[tcyc] = m_err;
      o_nrdy[tcyc] = !bus.in_ready; e_nrdy[tcyc] = (hold_left != 0);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 8'($urandom), 1'($urandom), a);
  endtask

  // Sends nbytes of val big-endian. gap_hi>0 inserts random idle cycles
  // (gap_lo..gap_hi) before every byte but the first. flip: -1 none,
  // -2 random in_is_key on later bytes, else invert in_is_key on that byte.
  task automatic send_frame(input logic [255:0] val, input int nbytes, input bit is_key,
                            input int gap_lo, input int gap_hi, input int flip,
                            output int first_acc);
    logic [7:0] d;
    bit k, acc;
    first_acc = -1;
    for (int b = 0; b < nbytes; b++) begin
      d = val[8*(nbytes-1-b) +: 8];
      if (b > 0) idle($urandom_range(gap_hi, gap_lo));
      k = is_key;
      if (b > 0 && flip == -2) k = 1'($urandom);
      else if (b == flip) k = !is_key;
      acc = 0;
      for (int t = 0; t < 40 && !acc; t++) step(1, d, k, acc);
      if (b == 0) first_acc = tcyc;
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout: byte %0d not accepted, got acc=%0d want 1", b, acc);
      end
    end
    bus.in_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = 0; bus.in_is_key = 0;
    do_reset();
    checks++; if (key !== 256'h0) begin errors++; $display("FAIL reset_key: got %h want 0", key); end
    checks++; if (ciphertext !== 64'h0) begin errors++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
    checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL reset_key_loaded: got %b want 0", key_loaded); end
    checks++; if ({key_update, dec_start, msg_strobe, err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000", {key_update, dec_start, msg_strobe, err}); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_no_key();
    bit a;
    win_start();
    step(1, 8'haa, 0, a);
    idle(3);
    checks++; if (o_err !== 128'h2) begin errors++; $display("FAIL nokey_err: got %h want 2", o_err); end
    checks++; if (ciphertext !== 64'h0) begin errors++; $display("FAIL nokey_ct: got %h want 0", ciphertext); end
    checks++; if (o_dec !== 128'h0) begin errors++; $display("FAIL nokey_dec: got %h want 0", o_dec); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nokey_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_key_load();
    int fa;
    win_start();
    send_frame(KEY_TV, 32, 1, 0, 0, -1, fa);
    idle(2);
    checks++; if (key !== KEY_TV) begin errors++; $display("FAIL key_value: got %h want %h", key, KEY_TV); end
    checks++; if (key_loaded !== 1'b1) begin errors++; $display("FAIL key_loaded: got %b want 1", key_loaded); end
    checks++; if (o_upd !== (128'h1 << 32)) begin errors++; $display("FAIL key_update: got %h want %h", o_upd, 128'h1 << 32); end
    checks++; if (ciphertext !== 64'h0) begin errors++; $display("FAIL key_ct_unchanged: got %h want 0", ciphertext); end
  endtask

  task automatic test_block();
    int fa;
    win_start();
    send_frame(CT_TV, 8, 0, 0, 0, -1, fa);
    checks++; if (ciphertext !== CT_TV[63:0]) begin errors++; $display("FAIL block_ct: got %h want %h", ciphertext, CT_TV[63:0]); end
    idle(4);
    checks++; if (o_dec !== (128'h1 << 8)) begin errors++; $display("FAIL block_dec: got %h want %h", o_dec, 128'h1 << 8); end
    checks++; if (o_msg !== (128'h1 << (8 + L - 1))) begin errors++; $display("FAIL block_msg: got %h want %h", o_msg, 128'h1 << (8 + L - 1)); end
    checks++; if (o_nrdy !== (128'h3 << 8)) begin errors++; $display("FAIL block_ready: got %h want %h", o_nrdy, 128'h3 << 8); end
    checks++;
    if ({o_dec, o_msg, o_upd, o_err, o_nrdy} !== {e_dec, e_msg, e_upd, e_err, e_nrdy}) begin
      errors++;
      $display("FAIL block_trace: got dec=%h msg=%h upd=%h err=%h nrdy=%h want dec=%h msg=%h upd=%h err=%h nrdy=%h",
               o_dec, o_msg, o_upd, o_err, o_nrdy, e_dec, e_msg, e_upd, e_err, e_nrdy);
    end
  endtask

  task automatic test_gapped();
    logic [255:0] v;
    int fa;
    v = {192'h0, $urandom, $urandom};
    win_start();
    send_frame(v, 8, 0, 3, 3, 3, fa);
    idle(4);
    checks++; if (ciphertext !== v[63:0]) begin errors++; $display("FAIL gap_ct: got %h want %h", ciphertext, v[63:0]); end
    checks++; if (o_dec !== (128'h1 << 29)) begin errors++; $display("FAIL gap_dec: got %h want %h", o_dec, 128'h1 << 29); end
    checks++; if (o_msg !== (128'h1 << (28 + L))) begin errors++; $display("FAIL gap_msg: got %h want %h", o_msg, 128'h1 << (28 + L)); end
    checks++; if (key !== KEY_TV) begin errors++; $display("FAIL gap_key_kept: got %h want %h", key, KEY_TV); end
  endtask

  task automatic test_reset_hold();
    int fa;
    win_start();
    send_frame(CT_TV, 8, 0, 0, 0, -1, fa);
    idle(1);
    rst_n = 0;
    #1;
    checks++; if ({key, ciphertext, key_loaded} !== 321'h0) begin
      errors++; $display("FAIL rsthold_values: got key=%h ct=%h loaded=%b want all 0", key, ciphertext, key_loaded); end
    checks++; if ({key_update, dec_start, msg_strobe, err} !== 4'b0) begin
      errors++; $display("FAIL rsthold_pulses: got %b want 0000", {key_update, dec_start, msg_strobe, err}); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rsthold_ready: got %b want 1", bus.in_ready); end
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1;
    win_start();
    idle(5);
    checks++; if (o_msg !== 128'h0) begin errors++; $display("FAIL rsthold_no_msg: got %h want 0", o_msg); end
    send_frame(KEY_TV, 32, 1, 0, 1, -1, fa);
    send_frame(CT_TV, 8, 0, 0, 1, -1, fa);
    idle(L + 2);
    checks++; if (ciphertext !== CT_TV[63:0] || key !== KEY_TV) begin
      errors++; $display("FAIL rsthold_reload: got ct=%h key=%h want ct=%h key=%h", ciphertext, key, CT_TV[63:0], KEY_TV); end
    checks++;
    if ({o_dec, o_msg, o_upd, o_err, o_nrdy} !== {e_dec, e_msg, e_upd, e_err, e_nrdy}) begin
      errors++;
      $display("FAIL rsthold_trace: got dec=%h msg=%h upd=%h err=%h nrdy=%h want dec=%h msg=%h upd=%h err=%h nrdy=%h",
               o_dec, o_msg, o_upd, o_err, o_nrdy, e_dec, e_msg, e_upd, e_err, e_nrdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] v1, v2;
    int fa1, fa2;
    v1 = {192'h0, $urandom, $urandom};
    v2 = {192'h0, $urandom, $urandom};
    win_start();
    send_frame(v1, 8, 0, 0, 0, -1, fa1);
    checks++; if (ciphertext !== v1[63:0]) begin errors++; $display("FAIL b2b_ct1: got %h want %h", ciphertext, v1[63:0]); end
    send_frame(v2, 8, 0, 0, 0, -1, fa2);
    idle(L + 2);
    checks++; if (fa2 !== 9 + L) begin errors++; $display("FAIL b2b_first_accept: got %0d want %0d", fa2, 9 + L); end
    checks++; if (ciphertext !== v2[63:0]) begin errors++; $display("FAIL b2b_ct2: got %h want %h", ciphertext, v2[63:0]); end
    checks++; if (o_dec !== ((128'h1 << 8) | (128'h1 << (16 + L)))) begin
      errors++; $display("FAIL b2b_dec: got %h want %h", o_dec, (128'h1 << 8) | (128'h1 << (16 + L))); end
    checks++; if (o_msg !== ((128'h1 << (7 + L)) | (128'h1 << (15 + 2 * L)))) begin
      errors++; $display("FAIL b2b_msg: got %h want %h", o_msg, (128'h1 << (7 + L)) | (128'h1 << (15 + 2 * L))); end
  endtask

  task automatic test_random();
    logic [255:0] v;
    bit is_key;
    int fa;
    do_reset();
    for (int n = 0; n < 14; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      is_key = (n == 2) || ($urandom_range(3, 0) == 0);
      win_start();
      send_frame(v, is_key ? 32 : 8, is_key, 0, 2, -2, fa);
      idle(L + 2);
      checks++;
      if (key !== m_key || ciphertext !== m_ct || key_loaded !== m_loaded) begin
        errors++;
        $display("FAIL rand_values[%0d]: got key=%h ct=%h loaded=%b want key=%h ct=%h loaded=%b",
                 n, key, ciphertext, key_loaded, m_key, m_ct, m_loaded);
      end
      checks++;
      if ({o_dec, o_msg, o_upd, o_err, o_nrdy} !== {e_dec, e_msg, e_upd, e_err, e_nrdy}) begin
        errors++;
        $display("FAIL rand_trace[%0d]: got dec=%h msg=%h upd=%h err=%h nrdy=%h want dec=%h msg=%h upd=%h err=%h nrdy=%h",
                 n, o_dec, o_msg, o_upd, o_err, o_nrdy, e_dec, e_msg, e_upd, e_err, e_nrdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_key_load();
    test_block();
    test_gapped();
    test_reset_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/magma_dec_loader.md
# magma_dec_loader

Byte-stream front end for the Magma (GOST 28147-89) decryption stage. Assembles a 256-bit key and 64-bit ciphertext blocks from a byte interface and presents them to the decryption core. The key changes only atomically; each ciphertext is held stable for the core's evaluation window. It signals the downstream consumer when `message` from the core is valid to sample.

## Interface
- `CORE_LATENCY`, default 2: cycles the ciphertext is held before `message` from the core is valid; legal range 1..15.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  8  byte payload
- `in_valid`  in  1  `in_data` / `in_is_key` valid
- `in_is_key`  in  1  frame type, sampled on the first byte of a frame: 1 = key frame (32 bytes), 0 = ciphertext frame (8 bytes)
- `in_ready`  out  1  loader accepts a byte this cycle
- `key`  out  [256:1]  key to the core; updated only on key-frame completion
- `ciphertext`  out  [64:1]  block to the core; updated only on ciphertext-frame completion
- `key_loaded`  out  1  a complete key has been received since reset
- `key_update`  out  1  one-cycle pulse after a key frame completes
- `dec_start`  out  1  one-cycle pulse, first cycle `ciphertext` holds a new block
- `msg_strobe`  out  1  one-cycle pulse; core `message` is valid this cycle
- `err`  out  1  one-cycle pulse: ciphertext frame attempted with no key loaded

## Operation
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- Byte order is big-endian. The first byte of a frame lands in `[256:249]` (key) or `[64:57]` (ciphertext). Bytes shift left into a shadow register.
- States: IDLE, LOAD_KEY, LOAD_CT, HOLD.
- IDLE, accept with `in_is_key=1`:
  - byte stored, byte count = 1, state goes to LOAD_KEY.
- IDLE, accept with `in_is_key=0`:
  - if `key_loaded=1`: byte stored, count = 1, state goes to LOAD_CT.
  - if `key_loaded=0`: byte consumed and dropped, `err` pulses next cycle, state stays IDLE.
- LOAD_KEY / LOAD_CT:
  - `in_is_key` is ignored; the frame type is latched.
  - Gaps (`in_valid=0`) are allowed without limit.
- 32nd key byte:
  - `key` <= `{shadow[248:1], in_data}`.
  - `key_loaded` <= 1.
  - `key_update` pulses next cycle.
  - state goes to IDLE; there is no HOLD.
- 8th ciphertext byte:
  - `ciphertext` <= `{shadow[56:1], in_data}`.
  - hold counter <= `CORE_LATENCY`.
  - state goes to HOLD.
- HOLD:
  - `in_ready=0`.
  - counter decrements each cycle.
  - `dec_start` is high in the first HOLD cycle.
  - `msg_strobe` is high in the last HOLD cycle (counter == 1).
  - next state is IDLE.
- If `CORE_LATENCY=1`, `dec_start` and `msg_strobe` are high in the same cycle.
- `key` and `ciphertext` never show partial frames. A key frame can start only from IDLE, so the key never changes during HOLD.
- Byte counter is 5 bits. It resets to 0 on frame completion.

## Timing
- Reset values, all asserted asynchronously:
  - `key`=0, `ciphertext`=0, `key_loaded`=0.
  - `key_update`=0, `dec_start`=0, `msg_strobe`=0, `err`=0.
  - state IDLE, so `in_ready=1` immediately after release.
- `in_ready`:
  - combinational from state: 1 in IDLE/LOAD_KEY/LOAD_CT, 0 in HOLD.
  - independent of `in_valid`.
- Ciphertext frame with no gaps, accepts at edges 1..8:
  - `ciphertext` is valid after edge 8.
  - `dec_start` is high in cycle 9.
  - `msg_strobe` is high in cycle 8+`CORE_LATENCY`.
  - `in_ready` returns in cycle 9+`CORE_LATENCY`.
- Back-to-back throughput: 8+`CORE_LATENCY` cycles per block.
- Key frame: `key_update` is high in the cycle after the 32nd accept. A ciphertext byte may be accepted in that same cycle.
- Reset mid-frame or mid-HOLD:
  - the partial shadow is discarded and `key_loaded` drops.
  - a pending `msg_strobe` is never issued.
- All pulse outputs are registered.

## Structure
- Shared package `magma_pkg`:
  - `BLOCK_W`=64, `KEY_W`=256.
  - `BYTES_PER_BLOCK`=8, `BYTES_PER_KEY`=32.
  - the loader state enum.
  - the decryption stage also uses these widths.
- One sub-module: `magma_shift_in`, a parameterised byte shift register (width W, load-enable, clear). Instantiate it twice: W=256 for the key shadow and W=64 for the ciphertext shadow.
- FSM, counters and pulse registers stay in the top module.

## Test plan
- **Key load:** 32 bytes `ff ee dd cc … 00 f0 f1 … fe ff` -> `key`=`ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff`, `key_loaded`=1, one `key_update` pulse, `ciphertext` unchanged.
- **Block, `CORE_LATENCY`=2:** 8 bytes `4e e9 01 e5 c2 d8 ca 3d` -> `ciphertext`=`4ee901e5c2d8ca3d` after edge 8, `dec_start` in cycle 9, `msg_strobe` in cycle 10, `in_ready` low in cycles 9–10; the core's `message` sampled on `msg_strobe` equals `fedcba9876543210`.
- **No key:** after reset, `in_is_key=0` byte `0xaa` -> byte consumed, `err` high one cycle, state IDLE, `ciphertext`=0, no `dec_start`.
- **Gapped/mixed input:** ciphertext frame with `in_valid` dropped 3 cycles between bytes and `in_is_key` toggled on byte 4 -> frame is still treated as ciphertext; same `ciphertext` and pulses, shifted by the gap cycles.
- **Reset mid-HOLD:** assert `rst_n`=0 one cycle after `dec_start` -> all outputs 0 immediately, no `msg_strobe`; a fresh key and block then decrypt correctly.
- **Back-to-back:** two blocks with `in_valid` held high -> the second block's first byte is accepted exactly in cycle 9+`CORE_LATENCY`, and each block gets exactly one `dec_start` and one `msg_strobe`.
